// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit count register: runs start_val..end_val up or down,
// one-shot or repeating, at one step per PRESCALE clocks, with pause/abort control.
module counter_seq_ctrl #(
    parameter int WIDTH    = 3,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    output logic [WIDTH-1:0] o,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [1:0]       state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] sv_q, sv_d;
    logic [WIDTH-1:0] ev_q, ev_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    psc_q, psc_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             run_cyc;

    function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] cur, input logic up);
        return up ? cur + WIDTH'(1) : cur - WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            o_q     <= '0;
            sv_q    <= '0;
            ev_q    <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            psc_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            sv_q    <= sv_d;
            ev_q    <= ev_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            psc_q   <= psc_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        sv_d    = sv_q;
        ev_d    = ev_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        psc_d   = psc_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        run_cyc = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sv_d    = start_val;
                    ev_d    = end_val;
                    dir_d   = dir;
                    mode_d  = mode;
                    o_d     = start_val;
                    psc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pause) state_d = PAUSE;
                else       run_cyc = 1'b1;
            end
            PAUSE: begin
                // The resume cycle counts as a running cycle so a P-cycle pause costs exactly P.
                if (!pause) begin
                    state_d = RUN;
                    run_cyc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (run_cyc) begin
            if (psc_q == PLAST) begin
                psc_d = '0;
                if (o_q != ev_q) begin
                    o_d = step_val(o_q, dir_q);
                end else if (mode_q) begin
                    o_d    = sv_q;
                    wrap_d = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end else begin
                psc_d = psc_q + PW'(1);
            end
        end

        if (abort) begin
            state_d = IDLE;
            o_d     = '0;
            psc_d   = '0;
            done_d  = 1'b0;
            wrap_d  = 1'b0;
        end
    end

    assign o     = o_q;
    assign done  = done_q;
    assign wrap  = wrap_q;
    assign state = state_q;
    assign busy  = (state_q == RUN) || (state_q == PAUSE);

endmodule
